// File: rtl/pipe_ctrl_unit.sv
// Pipeline stall/flush controller: prefix stall vector with one-hot bubble strobes,
// registered exception/ERET flush sequencer, and a stall watchdog with saturating counter.
module pipe_ctrl_unit #(
  parameter int NSTAGE    = 5,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 8,
  parameter int MAX_STALL = 200
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              flushreq,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] bubble,
  output logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              stall_timeout
);

  localparam int FCNT_W = $clog2(FLUSH_CYC) + 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                flush_q, flush_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic [NSTAGE-1:0]   req_prefix;
  logic                any_stall;

  // req_prefix[i] is set when stage i or any later stage asks to stall.
  always_comb begin
    logic acc;
    acc        = 1'b0;
    req_prefix = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc           = acc | stallreq[i];
      req_prefix[i] = acc;
    end
  end

  always_comb begin
    stall  = (cpu_rst || flush_q) ? '0 : req_prefix;
    bubble = '0;
    for (int i = 1; i < NSTAGE; i++) begin
      bubble[i] = stall[i-1] & ~stall[i];
    end
  end

  assign any_stall = (stall != '0);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (flushreq) begin
          state_d = FLUSH;
          fcnt_d  = FCNT_W'(FLUSH_CYC - 1);
        end
      end
      FLUSH: begin
        // Requests during a flush, including its last cycle, are dropped.
        if (fcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    flush_d = (state_d == FLUSH);
  end

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (flush_q || !any_stall) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (flush_q) begin
      timeout_d = 1'b0;
    end else if (any_stall && cnt_q >= CNT_W'(MAX_STALL - 1)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q   <= IDLE;
      fcnt_q    <= '0;
      flush_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      flush_q   <= flush_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign flush         = flush_q;
  assign stall_cnt     = cnt_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: three instances differing only in FLUSH_CYC (3, 1, 4).
module tb_pipe_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: FLUSH_CYC=3
  logic       a_rst, a_flushreq, a_flush, a_timeout;
  logic [4:0] a_stallreq, a_stall, a_bubble;
  logic [7:0] a_cnt;
  // Instance B: FLUSH_CYC=1
  logic       b_rst, b_flushreq, b_flush, b_timeout;
  logic [4:0] b_stallreq, b_stall, b_bubble;
  logic [7:0] b_cnt;
  // Instance C: FLUSH_CYC=4
  logic       c_rst, c_flushreq, c_flush, c_timeout;
  logic [4:0] c_stallreq, c_stall, c_bubble;
  logic [7:0] c_cnt;

  pipe_ctrl_unit #(.NSTAGE(5), .FLUSH_CYC(3), .CNT_W(8), .MAX_STALL(200)) u_dut_a (
    .cpu_clk_50M(clk), .cpu_rst(a_rst), .stallreq(a_stallreq), .flushreq(a_flushreq),
    .stall(a_stall), .bubble(a_bubble), .flush(a_flush), .stall_cnt(a_cnt),
    .stall_timeout(a_timeout));

  pipe_ctrl_unit #(.NSTAGE(5), .FLUSH_CYC(1), .CNT_W(8), .MAX_STALL(200)) u_dut_b (
    .cpu_clk_50M(clk), .cpu_rst(b_rst), .stallreq(b_stallreq), .flushreq(b_flushreq),
    .stall(b_stall), .bubble(b_bubble), .flush(b_flush), .stall_cnt(b_cnt),
    .stall_timeout(b_timeout));

  pipe_ctrl_unit #(.NSTAGE(5), .FLUSH_CYC(4), .CNT_W(8), .MAX_STALL(200)) u_dut_c (
    .cpu_clk_50M(clk), .cpu_rst(c_rst), .stallreq(c_stallreq), .flushreq(c_flushreq),
    .stall(c_stall), .bubble(c_bubble), .flush(c_flush), .stall_cnt(c_cnt),
    .stall_timeout(c_timeout));

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_flushreq = 1'b0; b_flushreq = 1'b0; c_flushreq = 1'b0;
    a_stallreq = 5'b00000; b_stallreq = 5'b00100; c_stallreq = 5'b00000;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (b_stall !== 5'b00000) begin n_fail++; $display("FAIL reset_stall: got %b expected %b", b_stall, 5'b00000); end
    n_checks++; if (b_bubble !== 5'b00000) begin n_fail++; $display("FAIL reset_bubble: got %b expected %b", b_bubble, 5'b00000); end
    n_checks++; if (b_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b expected 0", b_flush); end
    n_checks++; if (b_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", b_cnt); end
    n_checks++; if (b_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", b_timeout); end
    b_stallreq = 5'b00000;
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_stall_vector();
    logic [4:0] req_tab [5] = '{5'b00100, 5'b01010, 5'b00000, 5'b10000, 5'b00001};
    logic [4:0] stl_tab [5] = '{5'b00111, 5'b01111, 5'b00000, 5'b11111, 5'b00001};
    logic [4:0] bub_tab [5] = '{5'b01000, 5'b10000, 5'b00000, 5'b00000, 5'b00010};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b_stallreq = req_tab[i];
      #1;
      $display("stall_vector: stallreq=%b stall=%b bubble=%b", b_stallreq, b_stall, b_bubble);
      n_checks++; if (b_stall !== stl_tab[i]) begin n_fail++; $display("FAIL stall_vec[%0d]: got %b expected %b", i, b_stall, stl_tab[i]); end
      n_checks++; if (b_bubble !== bub_tab[i]) begin n_fail++; $display("FAIL bubble_vec[%0d]: got %b expected %b", i, b_bubble, bub_tab[i]); end
    end
    @(negedge clk);
    b_stallreq = 5'b00000;
    @(posedge clk); #1;
    n_checks++; if (b_cnt !== 8'd0) begin n_fail++; $display("FAIL idle_cnt: got %0d expected 0", b_cnt); end
  endtask

  task automatic test_flush_seq();
    logic exp;
    @(posedge clk); #1;
    a_flushreq = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      a_flushreq = (k >= 2 && k <= 4);
      exp = (k <= 3) || (k >= 5 && k <= 7);
      $display("flush_seq: cycle %0d flushreq=%b flush=%b", k, a_flushreq, a_flush);
      n_checks++; if (a_flush !== exp) begin n_fail++; $display("FAIL flush_seq[%0d]: got %b expected %b", k, a_flush, exp); end
    end
    a_flushreq = 1'b0;
  endtask

  task automatic test_stall_flush();
    @(posedge clk); #1;
    b_stallreq = 5'b00010; b_flushreq = 1'b1;
    #1;
    n_checks++; if (b_stall !== 5'b00011) begin n_fail++; $display("FAIL sf_stall_n: got %b expected %b", b_stall, 5'b00011); end
    n_checks++; if (b_bubble !== 5'b00100) begin n_fail++; $display("FAIL sf_bubble_n: got %b expected %b", b_bubble, 5'b00100); end
    n_checks++; if (b_cnt !== 8'd0) begin n_fail++; $display("FAIL sf_cnt_n: got %0d expected 0", b_cnt); end
    @(posedge clk); #1;
    b_flushreq = 1'b0;
    n_checks++; if (b_flush !== 1'b1) begin n_fail++; $display("FAIL sf_flush_n1: got %b expected 1", b_flush); end
    n_checks++; if (b_stall !== 5'b00000) begin n_fail++; $display("FAIL sf_stall_n1: got %b expected %b", b_stall, 5'b00000); end
    n_checks++; if (b_bubble !== 5'b00000) begin n_fail++; $display("FAIL sf_bubble_n1: got %b expected %b", b_bubble, 5'b00000); end
    n_checks++; if (b_cnt !== 8'd1) begin n_fail++; $display("FAIL sf_cnt_n1: got %0d expected 1", b_cnt); end
    @(posedge clk); #1;
    n_checks++; if (b_flush !== 1'b0) begin n_fail++; $display("FAIL sf_flush_n2: got %b expected 0", b_flush); end
    n_checks++; if (b_stall !== 5'b00011) begin n_fail++; $display("FAIL sf_stall_n2: got %b expected %b", b_stall, 5'b00011); end
    n_checks++; if (b_cnt !== 8'd0) begin n_fail++; $display("FAIL sf_cnt_n2: got %0d expected 0", b_cnt); end
    @(posedge clk); #1;
    n_checks++; if (b_cnt !== 8'd1) begin n_fail++; $display("FAIL sf_cnt_n3: got %0d expected 1", b_cnt); end
    $display("stall_flush: flush won the cycle after a simultaneous request");
    b_stallreq = 5'b00000;
    @(posedge clk); #1;
  endtask

  task automatic test_watchdog();
    b_stallreq = 5'b00100;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (k == 199) begin
        n_checks++; if (b_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_early: got %b expected 0", b_timeout); end
        n_checks++; if (b_cnt !== 8'd199) begin n_fail++; $display("FAIL wd_cnt199: got %0d expected 199", b_cnt); end
      end
      if (k == 200) begin
        n_checks++; if (b_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_trip: got %b expected 1", b_timeout); end
        n_checks++; if (b_cnt !== 8'd200) begin n_fail++; $display("FAIL wd_cnt200: got %0d expected 200", b_cnt); end
        $display("watchdog: tripped at stalled edge %0d", k);
      end
      if (k == 255) begin
        n_checks++; if (b_cnt !== 8'd255) begin n_fail++; $display("FAIL wd_cnt255: got %0d expected 255", b_cnt); end
      end
      if (k == 300) begin
        n_checks++; if (b_cnt !== 8'd255) begin n_fail++; $display("FAIL wd_sat: got %0d expected 255", b_cnt); end
        $display("watchdog: stall_cnt=%0d after %0d stalled edges", b_cnt, k);
      end
    end
    b_stallreq = 5'b00000;
    @(posedge clk); #1;
    n_checks++; if (b_cnt !== 8'd0) begin n_fail++; $display("FAIL wd_cnt_clr: got %0d expected 0", b_cnt); end
    n_checks++; if (b_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: got %b expected 1", b_timeout); end
    b_flushreq = 1'b1;
    @(posedge clk); #1;
    b_flushreq = 1'b0;
    n_checks++; if (b_flush !== 1'b1) begin n_fail++; $display("FAIL wd_flush: got %b expected 1", b_flush); end
    n_checks++; if (b_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_hold_in_flush: got %b expected 1", b_timeout); end
    @(posedge clk); #1;
    n_checks++; if (b_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_flush_clr: got %b expected 0", b_timeout); end
    n_checks++; if (b_flush !== 1'b0) begin n_fail++; $display("FAIL wd_flush_end: got %b expected 0", b_flush); end
    $display("watchdog: cleared by flush");
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    c_flushreq = 1'b1;
    @(posedge clk); #1;
    c_flushreq = 1'b0; c_stallreq = 5'b00100;
    n_checks++; if (c_flush !== 1'b1) begin n_fail++; $display("FAIL ar_flush1: got %b expected 1", c_flush); end
    n_checks++; if (c_stall !== 5'b00000) begin n_fail++; $display("FAIL ar_stall_masked: got %b expected %b", c_stall, 5'b00000); end
    @(posedge clk); #1;
    n_checks++; if (c_flush !== 1'b1) begin n_fail++; $display("FAIL ar_flush2: got %b expected 1", c_flush); end
    #2 c_rst = 1'b1;
    #1;
    n_checks++; if (c_flush !== 1'b0) begin n_fail++; $display("FAIL ar_flush_drop: got %b expected 0", c_flush); end
    n_checks++; if (c_stall !== 5'b00000) begin n_fail++; $display("FAIL ar_stall_rst: got %b expected %b", c_stall, 5'b00000); end
    #1 c_rst = 1'b0;
    #1;
    n_checks++; if (c_stall !== 5'b00111) begin n_fail++; $display("FAIL ar_stall_rel: got %b expected %b", c_stall, 5'b00111); end
    n_checks++; if (c_cnt !== 8'd0) begin n_fail++; $display("FAIL ar_cnt_rel: got %0d expected 0", c_cnt); end
    @(posedge clk); #1;
    n_checks++; if (c_flush !== 1'b0) begin n_fail++; $display("FAIL ar_idle: got %b expected 0", c_flush); end
    n_checks++; if (c_stall !== 5'b00111) begin n_fail++; $display("FAIL ar_stall_after: got %b expected %b", c_stall, 5'b00111); end
    n_checks++; if (c_cnt !== 8'd1) begin n_fail++; $display("FAIL ar_cnt_after: got %0d expected 1", c_cnt); end
    $display("async_reset: flush abandoned, unit idle after release");
    c_stallreq = 5'b00000;
  endtask

  initial begin
    test_reset();
    test_stall_vector();
    test_flush_seq();
    test_stall_flush();
    test_watchdog();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
